// File: rtl/uadd_pipe.sv
// Pipelined unsigned adder: the WIDTH-bit carry chain is cut into STAGES equal
// chunks, one register stage per chunk, behind a valid/ready handshake.
module uadd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CH = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
    $error("uadd_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  function automatic logic [CH:0] chunk_add(input logic [CH-1:0] x,
                                            input logic [CH-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CH{1'b0}}, c};
  endfunction

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] carry_p;
  logic [WIDTH-1:0]  sum_p [STAGES];
  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  b_p   [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] carry_in;
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [WIDTH-1:0]  sum_nx [STAGES];
  logic [STAGES-1:0] carry_nx;
  logic              in_fire;

  // A stage may advance if it, or any stage downstream of it, has a free slot,
  // or the output is being drained this cycle.
  always_comb begin
    logic open_slot;
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      open_slot = out_ready;
      for (int j = k; j < STAGES; j++) open_slot = open_slot | ~vld_p[j];
      adv[k] = open_slot;
    end
  end

  assign in_ready = adv[0] & ~rst;
  assign in_fire  = in_valid & in_ready;

  // Stage inputs: stage 0 takes the ports, stage k takes the stage k-1 registers.
  always_comb begin
    vld_in   = '0;
    carry_in = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_in[k] = '0;
      a_in[k]   = '0;
      b_in[k]   = '0;
    end
    vld_in[0]   = in_fire;
    carry_in[0] = cin;
    a_in[0]     = a;
    b_in[0]     = b;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k]   = vld_p[k-1];
      carry_in[k] = carry_p[k-1];
      sum_in[k]   = sum_p[k-1];
      a_in[k]     = a_p[k-1];
      b_in[k]     = b_p[k-1];
    end
  end

  // Each stage resolves its own chunk and forwards the chunk carry.
  always_comb begin
    logic [CH:0] res;
    carry_nx = '0;
    for (int k = 0; k < STAGES; k++) begin
      res                   = chunk_add(a_in[k][k*CH +: CH], b_in[k][k*CH +: CH], carry_in[k]);
      sum_nx[k]             = sum_in[k];
      sum_nx[k][k*CH +: CH] = res[CH-1:0];
      carry_nx[k]           = res[CH];
    end
  end

  // Pipeline registers p0..p(STAGES-1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p   <= '0;
      carry_p <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_p[k] <= '0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_p[k]   <= vld_in[k];
          carry_p[k] <= carry_nx[k];
          sum_p[k]   <= sum_nx[k];
          a_p[k]     <= a_in[k];
          b_p[k]     <= b_in[k];
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign sum       = sum_p[STAGES-1];
  assign cout      = carry_p[STAGES-1];

endmodule

// File: tb/tb_uadd_pipe.sv
// Directed bench for uadd_pipe: an 8-bit/2-stage instance and a 3-bit/1-stage instance.
module tb_uadd_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       cin3 = 1'b0;
  logic       out_valid3;
  logic       out_ready3 = 1'b1;
  logic [2:0] sum3;
  logic       cout3;

  int n_vec = 0;
  int n_err = 0;

  uadd_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  uadd_pipe #(.WIDTH(3), .STAGES(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .cin(cin3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sum(sum3), .cout(cout3)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int         cnt_out;
  int         first_cyc;
  int         last_cyc;

  initial begin
    // reset state
    step();
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_sum", sum, 0);
    chk_eq("rst_cout", cout, 0);
    chk_eq("rst_in_ready", in_ready, 0);
    chk_eq("rst_out_valid3", out_valid3, 0);
    rst = 1'b0;
    step();

    // 1: 0x7F + 0x01, latency 2
    out_ready = 1'b1;
    drive(8'h7F, 8'h01, 1'b0);
    #1 chk_eq("t1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk_eq("t1_lat1_valid", out_valid, 0);
    step();
    chk_eq("t1_valid", out_valid, 1);
    chk_eq("t1_sum", sum, 8'h80);
    chk_eq("t1_cout", cout, 0);
    step();

    // 2: carry across the chunk boundary, back to back
    drive(8'hFF, 8'h01, 1'b0);
    step();
    drive(8'hFF, 8'hFF, 1'b1);
    step();
    in_valid = 1'b0;
    chk_eq("t2a_valid", out_valid, 1);
    chk_eq("t2a_sum", sum, 8'h00);
    chk_eq("t2a_cout", cout, 1);
    step();
    chk_eq("t2b_valid", out_valid, 1);
    chk_eq("t2b_sum", sum, 8'hFF);
    chk_eq("t2b_cout", cout, 1);
    step();
    chk_eq("t2_drain", out_valid, 0);

    // 3: single-stage 3-bit instance
    in_valid3 = 1'b1; a3 = 3'b010; b3 = 3'b100; cin3 = 1'b0;
    step();
    a3 = 3'b111; b3 = 3'b001; cin3 = 1'b1;
    chk_eq("t3a_valid", out_valid3, 1);
    chk_eq("t3a_sum", sum3, 3'b110);
    chk_eq("t3a_cout", cout3, 0);
    step();
    in_valid3 = 1'b0;
    chk_eq("t3b_sum", sum3, 3'b001);
    chk_eq("t3b_cout", cout3, 1);
    step();
    chk_eq("t3_drain", out_valid3, 0);

    // 4: back-pressure fills both stages
    out_ready = 1'b0;
    drive(8'd1, 8'd1, 1'b0);
    step();
    drive(8'd2, 8'd2, 1'b0);
    #1 chk_eq("t4_ready_2nd", in_ready, 1);
    step();
    drive(8'd3, 8'd3, 1'b0);
    #1 chk_eq("t4_full_ready", in_ready, 0);
    step();
    step();
    chk_eq("t4_stall_valid", out_valid, 1);
    chk_eq("t4_stall_sum", sum, 8'h02);
    chk_eq("t4_stall_ready", in_ready, 0);
    out_ready = 1'b1;
    #1 chk_eq("t4_ready_comb", in_ready, 1);
    step();
    chk_eq("t4_sum2", sum, 8'h04);
    drive(8'd4, 8'd4, 1'b0);
    step();
    in_valid = 1'b0;
    chk_eq("t4_sum3", sum, 8'h06);
    step();
    chk_eq("t4_sum4", sum, 8'h08);
    chk_eq("t4_valid4", out_valid, 1);
    step();
    chk_eq("t4_drain", out_valid, 0);

    // 5: 16 random pairs back to back against a+b+cin
    cnt_out   = 0;
    first_cyc = -1;
    last_cyc  = -1;
    begin
      int sent;
      sent = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (sent < 16) drive(8'($urandom), 8'($urandom), 1'($urandom));
        else in_valid = 1'b0;
        #1;
        if (in_valid && in_ready) begin
          exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
          sent++;
        end
        step();
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk_eq("t5_unexpected", out_valid, 0);
          end else begin
            exp_v = exp_q.pop_front();
            chk_eq("t5_result", {cout, sum}, exp_v);
          end
          cnt_out++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
    chk_eq("t5_count", cnt_out, 16);
    chk_eq("t5_consecutive", last_cyc - first_cyc + 1, 16);

    // 6: reset with two results in flight
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 1'b0);
    step();
    drive(8'h33, 8'h44, 1'b1);
    step();
    in_valid = 1'b0;
    chk_eq("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk_eq("t6_rst_valid", out_valid, 0);
    chk_eq("t6_rst_sum", sum, 0);
    chk_eq("t6_rst_cout", cout, 0);
    chk_eq("t6_rst_ready", in_ready, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(8'h10, 8'h20, 1'b0);
    step();
    in_valid = 1'b0;
    chk_eq("t6_no_stale", out_valid, 0);
    step();
    chk_eq("t6_valid", out_valid, 1);
    chk_eq("t6_sum", sum, 8'h30);
    chk_eq("t6_cout", cout, 0);
    step();
    chk_eq("t6_drain", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
